segundos: RTL and testbench

//  Seconds stage of the clock and initiator of the minute-advance line consumed by the minutes counter.

---
 rtl/relogio_pkg.sv | 19 +
 rtl/segundos_debouncer.sv | 59 +++++
 rtl/segundos.sv | 190 +++++++++++++++++++
 tb/tb_segundos.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
// Shared constants and types for the clock chain (seconds -> minutes).
// Small helpers used to size counters from module parameters.
package relogio_pkg;

   localparam int SEC_MAX = 59;
   localparam int SEC_W   = 6;
   localparam int PEND_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } inc_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/segundos_debouncer.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// level_o only changes after the synchronised input differs for DEBOUNCE cycles.
module debouncer #(
   parameter int DEBOUNCE = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic          rise_q;
   logic          rise_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any cycle where the input agrees with the level restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/segundos.sv
// Seconds stage: 1 s prescaler, 0..59 counter and the minute-advance pulser.
// Rollovers and set-button presses queue into a small pending counter.
module segundos
   import relogio_pkg::*;
#(
   parameter int CLK_DIV       = 50_000_000,
   parameter int INC_HOLD      = 4,
   parameter int INC_GAP       = 4,
   parameter int DEBOUNCE      = 1_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             set_btn_i,
   output logic             inc_o,
   output logic [SEC_W-1:0] segundos_o,
   output logic             ovf_o
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam int HW = $clog2(max2(INC_HOLD, INC_GAP) + 1);

   localparam logic [PW-1:0]     PRE_LAST  = PW'(CLK_DIV - 1);
   localparam logic [RW-1:0]     DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]     PER_LAST  = RW'(REPEAT_PERIOD - 1);
   localparam logic [HW-1:0]     HOLD_LAST = HW'(INC_HOLD - 1);
   localparam logic [HW-1:0]     GAP_LAST  = HW'(INC_GAP - 1);
   localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   logic              btn_level;
   logic              btn_rise;

   logic [PW-1:0]     pre_q;
   logic [PW-1:0]     pre_d;
   logic [SEC_W-1:0]  sec_q;
   logic [SEC_W-1:0]  sec_d;
   logic [RW-1:0]     rep_q;
   logic [RW-1:0]     rep_d;
   logic              first_q;
   logic              first_d;
   logic [PEND_W-1:0] pend_q;
   logic [PEND_W-1:0] pend_d;
   logic              ovf_q;
   logic              ovf_d;
   inc_state_t        state_q;
   inc_state_t        state_d;
   logic [HW-1:0]     hc_q;
   logic [HW-1:0]     hc_d;
   logic              inc_q;
   logic              inc_d;

   logic              tick;
   logic              rq_roll;
   logic              rq_rep;
   logic              rq_btn;
   logic              start;
   logic [PEND_W:0]   pend_sum;

   debouncer #(
      .DEBOUNCE (DEBOUNCE)
   ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (set_btn_i),
      .level_o (btn_level),
      .rise_o  (btn_rise)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q   <= '0;
         sec_q   <= '0;
         rep_q   <= '0;
         first_q <= 1'b1;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         state_q <= IDLE;
         hc_q    <= '0;
         inc_q   <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         rep_q   <= rep_d;
         first_q <= first_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         hc_q    <= hc_d;
         inc_q   <= inc_d;
      end
   end

   assign tick = en_i && (pre_q == PRE_LAST);

   always_comb begin
      pre_d   = pre_q;
      sec_d   = sec_q;
      rq_roll = 1'b0;
      if (en_i) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
         if (sec_q == SEC_LAST) begin
            sec_d   = '0;
            rq_roll = 1'b1;
         end else begin
            sec_d = sec_q + 1'b1;
         end
      end
   end

   // Auto-repeat: the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
   always_comb begin
      rep_d   = '0;
      first_d = 1'b1;
      rq_rep  = 1'b0;
      if (btn_level && !btn_rise) begin
         first_d = first_q;
         if (rep_q == (first_q ? DLY_LAST : PER_LAST)) begin
            rq_rep  = 1'b1;
            first_d = 1'b0;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   assign rq_btn = btn_rise | rq_rep;

   // A new pulse may start from IDLE or straight out of the last GAP cycle.
   assign start = (pend_q != '0) &&
                  ((state_q == IDLE) ||
                   ((state_q == GAP) && (hc_q == GAP_LAST)));

   always_comb begin
      pend_sum = {1'b0, pend_q}
               + {{PEND_W{1'b0}}, rq_roll}
               + {{PEND_W{1'b0}}, rq_btn}
               - {{PEND_W{1'b0}}, start};
      ovf_d    = ovf_q;
      pend_d   = pend_sum[PEND_W-1:0];
      if (pend_sum > {1'b0, PEND_MAX}) begin
         pend_d = PEND_MAX;
         ovf_d  = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HIGH;
               hc_d    = '0;
            end
         end
         HIGH: begin
            if (hc_q == HOLD_LAST) begin
               state_d = GAP;
               hc_d    = '0;
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         GAP: begin
            if (hc_q == GAP_LAST) begin
               state_d = start ? HIGH : IDLE;
               hc_d    = '0;
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hc_d    = '0;
         end
      endcase
      inc_d = (state_d == HIGH);
   end

   assign inc_o      = inc_q;
   assign segundos_o = sec_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_segundos.sv
// Directed plus randomized bench for segundos against a cycle-level
// behavioural model built from sample histories and a pulse timer.
module tb_segundos;

   localparam int CD = 4;
   localparam int IH = 2;
   localparam int IG = 2;
   localparam int DB = 3;
   localparam int RD = 20;
   localparam int RP = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       btn;
   logic       inc;
   logic [5:0] sec;
   logic       ovf;

   logic       rst2;
   logic       btn2;
   logic       inc2;
   logic [5:0] sec2;
   logic       ovf2;

   segundos #(
      .CLK_DIV       (CD),
      .INC_HOLD      (IH),
      .INC_GAP       (IG),
      .DEBOUNCE      (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .set_btn_i  (btn),
      .inc_o      (inc),
      .segundos_o (sec),
      .ovf_o      (ovf)
   );

   // Long pulse window so button presses can outrun the pulser.
   segundos #(
      .CLK_DIV       (CD),
      .INC_HOLD      (24),
      .INC_GAP       (24),
      .DEBOUNCE      (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut2 (
      .clk_i      (clk),
      .rst_i      (rst2),
      .en_i       (1'b0),
      .set_btn_i  (btn2),
      .inc_o      (inc2),
      .segundos_o (sec2),
      .ovf_o      (ovf2)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   int m_pre, m_sec, m_pend, m_tp, m_n, m_rn;
   bit m_ovf, m_lvl, m_inc;
   bit hist[$];

   int pc, hc, pc2;
   bit inc_prev = 1'b0;
   bit inc2_prev = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model();
      int  roll, rq, leave, d;
      bit  flip;
      m_n++;
      if (rst) begin
         m_pre = 0; m_sec = 0; m_pend = 0; m_tp = -1;
         m_ovf = 0; m_lvl = 0; m_inc = 0; m_rn = -1000;
         hist.delete();
         for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
         return;
      end
      roll = 0;
      if (en && m_pre == CD - 1) begin
         roll  = (m_sec == 59) ? 1 : 0;
         m_sec = (m_sec + 1) % 60;
      end
      if (en) m_pre = (m_pre + 1) % CD;
      rq = 0;
      if (m_lvl) begin
         d  = m_n - (m_rn + 1);
         rq = (d == 0 || (d >= RD && (d - RD) % RP == 0)) ? 1 : 0;
      end
      flip = 1'b1;
      for (int i = 1; i <= DB; i++)
         if (hist[i] == m_lvl) flip = 1'b0;
      if (flip) begin
         m_lvl = !m_lvl;
         if (m_lvl) m_rn = m_n;
      end
      hist.push_front(btn);
      void'(hist.pop_back());
      leave = ((m_tp < 0 || m_tp == IH + IG - 1) && m_pend > 0) ? 1 : 0;
      if (leave == 1) m_tp = 0;
      else if (m_tp >= 0) begin
         m_tp++;
         if (m_tp == IH + IG) m_tp = -1;
      end
      m_pend = m_pend + roll + rq - leave;
      if (m_pend > 3) begin
         m_pend = 3;
         m_ovf  = 1'b1;
      end
      m_inc = (m_tp >= 0 && m_tp < IH);
   endtask

   task automatic step();
      @(posedge clk);
      model();
      #1;
      chk("inc_o", {7'd0, inc}, {7'd0, m_inc});
      chk("segundos_o", {2'd0, sec}, 8'(m_sec));
      chk("ovf_o", {7'd0, ovf}, {7'd0, m_ovf});
      if (inc && !inc_prev) pc++;
      if (inc) hc++;
      inc_prev = inc;
      if (inc2 && !inc2_prev) pc2++;
      inc2_prev = inc2;
   endtask

   initial begin
      int run;
      rst = 1'b1; en = 1'b0; btn = 1'b0;
      rst2 = 1'b1; btn2 = 1'b0;
      m_n = 0;
      step(); step();
      chk("rst_sec", {2'd0, sec}, 8'd0);
      chk("rst_inc", {7'd0, inc}, 8'd0);
      chk("rst_ovf", {7'd0, ovf}, 8'd0);
      rst = 1'b0; rst2 = 1'b0;

      // one full minute
      en = 1'b1; pc = 0; hc = 0;
      repeat (236) step();
      chk("t1_sec59", {2'd0, sec}, 8'd59);
      repeat (4) step();
      chk("t1_wrap", {2'd0, sec}, 8'd0);
      chk("t1_nolat", {7'd0, inc}, 8'd0);
      step();
      chk("t1_rise", {7'd0, inc}, 8'd1);
      repeat (3) step();
      chk("t1_pulses", 8'(pc), 8'd1);
      chk("t1_width", 8'(hc), 8'(IH));

      // freeze at 17 mid-prescale
      for (int i = 0; i < 400 && m_sec != 17; i++) step();
      chk("t2_reach", {2'd0, sec}, 8'd17);
      step(); step();
      en = 1'b0;
      repeat (50) step();
      chk("t2_hold", {2'd0, sec}, 8'd17);
      en = 1'b1;
      run = 0;
      for (int i = 0; i < 10 && sec == 6'd17; i++) begin
         step();
         run++;
      end
      chk("t2_resume", 8'(run), 8'(CD - 2));
      en = 1'b0;

      // bounces then a short stable press
      repeat (10) step();
      pc = 0;
      btn = 1'b1; step(); btn = 1'b0; step(); step();
      btn = 1'b1; step(); btn = 1'b0; step(); step();
      btn = 1'b1; repeat (5) step();
      btn = 1'b0; repeat (20) step();
      chk("t3_single", 8'(pc), 8'd1);

      // long hold with auto-repeat
      pc = 0;
      btn = 1'b1; repeat (45) step();
      btn = 1'b0; repeat (20) step();
      chk("t3_repeat", 8'(pc), 8'd4);

      // debounced rise aligned with the rollover tick
      en = 1'b1;
      for (int i = 0; i < 400 && !(m_sec == 58 && m_pre == 2); i++)
         step();
      chk("t4_align", {2'd0, sec}, 8'd58);
      pc = 0;
      btn = 1'b1; repeat (8) step();
      btn = 1'b0; repeat (20) step();
      chk("t4_pulses", 8'(pc), 8'd2);
      chk("t4_ovf", {7'd0, ovf}, 8'd0);
      en = 1'b0;

      // reset during HIGH
      btn = 1'b1; repeat (5) step();
      btn = 1'b0;
      for (int i = 0; i < 20 && !inc; i++) step();
      chk("t6_high", {7'd0, inc}, 8'd1);
      rst = 1'b1; step();
      chk("t6h_inc", {7'd0, inc}, 8'd0);
      chk("t6h_sec", {2'd0, sec}, 8'd0);
      rst = 1'b0; pc = 0;
      repeat (20) step();
      chk("t6h_resid", 8'(pc), 8'd0);

      // reset during GAP
      btn = 1'b1; repeat (5) step();
      btn = 1'b0;
      for (int i = 0; i < 20 && !inc; i++) step();
      for (int i = 0; i < 20 && inc; i++) step();
      chk("t6_gap", {7'd0, inc}, 8'd0);
      rst = 1'b1; step();
      chk("t6g_ovf", {7'd0, ovf}, 8'd0);
      rst = 1'b0; pc = 0;
      repeat (20) step();
      chk("t6g_resid", 8'(pc), 8'd0);

      // saturation on the long-window instance
      pc2 = 0;
      for (int p = 0; p < 6; p++) begin
         btn2 = 1'b1; repeat (4) step();
         btn2 = 1'b0; repeat (4) step();
         if (p == 2) chk("t5_pre_ovf", {7'd0, ovf2}, 8'd0);
      end
      repeat (250) step();
      chk("t5_pulses", 8'(pc2), 8'd4);
      chk("t5_ovf", {7'd0, ovf2}, 8'd1);
      repeat (10) step();
      chk("t5_sticky", {7'd0, ovf2}, 8'd1);
      rst2 = 1'b1; step();
      chk("t5_rst_ovf", {7'd0, ovf2}, 8'd0);
      chk("t5_rst_inc", {7'd0, inc2}, 8'd0);
      rst2 = 1'b0;

      // randomized traffic
      run = 0;
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) en = ~en;
         if (run == 0) begin
            btn = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 30);
         end
         run--;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
